// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads 1- or 2-byte instructions from a byte-wide command
// memory and hands them to the controller over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int ADDR_W       = 13,
  parameter int READ_LATENCY = 1,
  parameter int RESET_PC     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] address,
  output logic              mem_read,
  input  logic [7:0]        command,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [15:0]       instr,
  output logic              instr_len,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, HOLD} state_t;

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic [7:0]        b0;
  logic              last;
  logic              two_byte;

  assign pc_next  = pc + ADDR_W'(1);
  assign last     = (wait_cnt == CNT_W'(READ_LATENCY - 1));
  // Opcodes 0xxx and 110x carry an operand byte; 10xx and 111x are single-byte.
  assign two_byte = ~command[7] | (command[7:5] == 3'b110);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= ADDR_W'(RESET_PC);
      address     <= '0;
      mem_read    <= 1'b0;
      wait_cnt    <= '0;
      b0          <= '0;
      instr       <= '0;
      instr_len   <= 1'b0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (pc_load) begin
      // Redirect wins over everything: any partial fetch or held instruction is dropped.
      pc          <= pc_in;
      instr_valid <= 1'b0;
      wait_cnt    <= '0;
      if (fetch_en) begin
        state    <= RD0;
        mem_read <= 1'b1;
        address  <= pc_in;
      end else begin
        state    <= IDLE;
        mem_read <= 1'b0;
        address  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) begin
            state    <= RD0;
            mem_read <= 1'b1;
            address  <= pc;
            wait_cnt <= '0;
          end
        end
        RD0: begin
          if (last) begin
            wait_cnt <= '0;
            b0       <= command;
            instr_pc <= pc;
            pc       <= pc_next;
            if (two_byte) begin
              state   <= RD1;
              address <= pc_next;
            end else begin
              state       <= HOLD;
              mem_read    <= 1'b0;
              address     <= '0;
              instr       <= {command, 8'h00};
              instr_len   <= 1'b0;
              instr_valid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RD1: begin
          if (last) begin
            wait_cnt    <= '0;
            pc          <= pc_next;
            state       <= HOLD;
            mem_read    <= 1'b0;
            address     <= '0;
            instr       <= {b0, command};
            instr_len   <= 1'b1;
            instr_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (fetch_en) begin
              state    <= RD0;
              mem_read <= 1'b1;
              address  <= pc;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the byte-wide command-memory read interface (13-bit address, 8-bit `command`, `mem_read`).
- Walks a program counter and reads one byte per access. It assembles variable-length instructions (1 or 2 bytes) from the 3/4-bit opcode in byte 0.
- Delivers each instruction to the controller over a valid/ready handshake. Supports PC redirect for JMP.

Parameters:
- ADDR_W, 13, memory address width; PC wraps modulo 2^ADDR_W.
- READ_LATENCY, 1, cycles `mem_read`/`address` are held before `command` is sampled (≥1).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- fetch_en  in  1  permits starting a new instruction fetch.
- address  out  ADDR_W  memory byte address.
- mem_read  out  1  memory read strobe.
- command  in  8  memory read data.
- pc_load  in  1  redirect request.
- pc_in  in  ADDR_W  redirect target.
- instr  out  16  assembled instruction; 2-byte = {b0,b1}, 1-byte = {b0,8'h00}.
- instr_len  out  1  0 = 1-byte, 1 = 2-byte.
- instr_pc  out  ADDR_W  address of byte 0 of `instr`.
- instr_valid  out  1  `instr`/`instr_len`/`instr_pc` are valid.
- instr_ready  in  1  consumer accepts the instruction.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pc=RESET_PC, address=0, mem_read=0.
  - instr=0, instr_len=0, instr_pc=0, instr_valid=0, wait counter=0.
  - Reset asserted mid-fetch aborts immediately; no partial instruction survives.
- States: IDLE, RD0, RD1, HOLD.
  - `mem_read`=1 only in RD0/RD1. `address`=pc in RD0/RD1, else 0.
- IDLE: if fetch_en → RD0 next cycle.
- RD0: hold address/mem_read for READ_LATENCY cycles.
  - On the edge ending the last cycle, capture command as b0, instr_pc←pc, pc←pc+1 (wrap).
  - Decode b0:
    - b0[7]=0 or b0[7:5]=3'b110 → 2-byte, go RD1.
    - b0[7:5]=3'b111 or b0[7:6]=2'b10 → 1-byte, go HOLD.
- RD1: same timing; capture b1, pc←pc+1 (wrap), go HOLD.
- HOLD: instr_valid=1; outputs stable while instr_ready=0.
  - On valid&ready edge: instr_valid←0, next state RD0 if fetch_en else IDLE.
- Throughput with READ_LATENCY=1, ready held high:
  - 1-byte instruction every 2 cycles; 2-byte every 3 cycles.
  - First instr_valid 2 cycles after leaving IDLE (1-byte) or 3 cycles (2-byte).
- fetch_en deasserted mid-fetch: the in-flight instruction completes and is presented; no new fetch starts.
- pc_load (highest priority, any state):
  - pc←pc_in, instr_valid←0, partial b0 discarded, wait counter cleared.
  - Next state RD0 if fetch_en else IDLE.
  - With pc_load and valid&ready in the same cycle, the held instruction counts as consumed, then the redirect applies.
- Wrap-around: a 2-byte instruction at pc=2^ADDR_W−1 takes b1 from address 0; pc afterwards = 1.
- `command` is sampled only on the capture edge; values at other times are ignored.
- The block never writes memory.

Test Plan:
1. Basic decode:
   - Stimulus: READ_LATENCY=1, mem[0..3]=E1,03,E8,94, ready=1, fetch_en=1 after reset.
   - Required: (instr=E100, len=0, pc=0), (03E8, 1, 1), (9400, 0, 3), in that order.
   - Required: address sequence 0,1,2,3; first valid 2 cycles after leaving IDLE.
2. Backpressure:
   - Stimulus: scenario 1, ready=0 for 5 cycles while the 03E8 instruction is presented.
   - Required: instr/len/pc stable and mem_read=0 during the stall; one cycle after ready=1, RD0 fetches address 3.
3. Redirect:
   - Stimulus: pc_load=1, pc_in=10 during RD1 of a 2-byte fetch; mem[10]=C0, mem[11]=0A.
   - Required: partial instruction discarded; next delivered instr=C00A, len=1, pc=10.
4. Wrap:
   - Stimulus: pc_load with pc_in=8191; mem[8191]=40, mem[0]=05.
   - Required: instr=4005, instr_pc=8191; next fetch address=1.
5. Latency:
   - Stimulus: READ_LATENCY=3, 1-byte instr E1 at address 0.
   - Required: mem_read high exactly 3 cycles with address=0; instr_valid in the 4th cycle; command glitches in cycles 1–2 ignored.
6. Reset mid-operation:
   - Stimulus: rst low during RD1, then released with fetch_en=1.
   - Required: all outputs at reset values immediately; fetch restarts at RESET_PC.
